// File: rtl/led_count_display.sv
// led_count_display: sequential double-dabble BCD conversion of an 8-bit count, multiplexed onto a 4-digit common-anode display
module led_count_display #(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  value,
   output logic [11:0] bcd,
   output logic        bcd_valid,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   localparam int PW = $clog2(CLK_DIV);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t state, state_n;
   logic [19:0] sr, sr_n, sr_adj;
   logic [2:0] cnt, cnt_n;
   logic force_conv, force_n;
   logic [7:0] last, last_n;
   logic [11:0] bcd_n;
   logic bcd_valid_n;
   logic [PW-1:0] pre;
   logic [1:0] idx;
   logic [3:0] nib;
   logic blank;
   logic [6:0] enc;
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 3; i++)
         sr_adj[8+4*i +: 4] = (sr[8+4*i +: 4] >= 4'd5) ? sr[8+4*i +: 4] + 4'd3 : sr[8+4*i +: 4];
   end
   always_comb begin
      state_n = state;
      sr_n = sr;
      cnt_n = cnt;
      force_n = force_conv;
      last_n = last;
      bcd_n = bcd;
      bcd_valid_n = bcd_valid;
      case (state)
         IDLE: if (value != last || force_conv) begin
            sr_n = {12'b0, value};
            last_n = value;
            force_n = 1'b0;
            cnt_n = '0;
            state_n = SHIFT;
         end
         SHIFT: begin
            sr_n = sr_adj << 1;
            cnt_n = cnt + 3'd1;
            state_n = (cnt == 3'd7) ? DONE : SHIFT;
         end
         DONE: begin
            bcd_n = sr[19:8];
            bcd_valid_n = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr <= '0;
         cnt <= '0;
         force_conv <= 1'b1;
         last <= '0;
         bcd <= '0;
         bcd_valid <= 1'b0;
      end else begin
         state <= state_n;
         sr <= sr_n;
         cnt <= cnt_n;
         force_conv <= force_n;
         last <= last_n;
         bcd <= bcd_n;
         bcd_valid <= bcd_valid_n;
      end
   end
   assign nib = (idx == 2'd2) ? bcd[11:8] : (idx == 2'd1) ? bcd[7:4] : bcd[3:0];
   assign blank = (idx == 2'd3) || ((idx == 2'd2) ? bcd[11:8] == 4'd0 : (idx == 2'd1) ? bcd[11:4] == 8'd0 : 1'b0);
   always_comb begin
      enc = 7'b1111111;
      case (nib)
         4'd0: enc = 7'b1000000;
         4'd1: enc = 7'b1111001;
         4'd2: enc = 7'b0100100;
         4'd3: enc = 7'b0110000;
         4'd4: enc = 7'b0011001;
         4'd5: enc = 7'b0010010;
         4'd6: enc = 7'b0000010;
         4'd7: enc = 7'b1111000;
         4'd8: enc = 7'b0000000;
         4'd9: enc = 7'b0010000;
         default: enc = 7'b1111111;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PW'(CLK_DIV - 1)) begin
         pre <= '0;
         idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
         pre <= pre + PW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (rst || !bcd_valid || blank) begin
         an <= 4'b1111;
         seg <= 7'b1111111;
      end else begin
         an <= ~(4'b0001 << idx);
         seg <= enc;
      end
   end
   assign dp = 1'b1;
endmodule

// File: tb/tb_led_count_display.sv
// tb_led_count_display: table, random and corner-sequence checks of led_count_display against a decimal-digit model
module tb_led_count_display;
   localparam int CLK_DIV = 4;
   typedef struct {
      int          v;
      logic [11:0] exp_bcd;
   } vec_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] value = 8'd0;
   logic [11:0] bcd;
   logic bcd_valid;
   logic [3:0] an;
   logic [6:0] seg;
   logic dp;
   int n_chk = 0;
   int n_fail = 0;
   logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   vec_t tbl [4];

   led_count_display #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .value(value), .bcd(bcd), .bcd_valid(bcd_valid),
      .an(an), .seg(seg), .dp(dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scan_check(input int v);
      int d [3];
      bit lit [3];
      int cnt [3];
      int nblank, nlit, prev, k;
      d[0] = v % 10;
      d[1] = (v / 10) % 10;
      d[2] = v / 100;
      lit[0] = 1'b1;
      lit[1] = v >= 10;
      lit[2] = v >= 100;
      cnt = '{0, 0, 0};
      nblank = 0;
      prev = -1;
      for (int c = 0; c < 3 * CLK_DIV; c++) begin
         @(negedge clk);
         chk("dp_off", 32'(dp), 32'd1);
         k = -1;
         case (an)
            4'b1111: begin
               nblank++;
               chk("seg_blank", 32'(seg), 32'h7f);
            end
            4'b1110: k = 0;
            4'b1101: k = 1;
            4'b1011: k = 2;
            default: chk("an_legal", 32'(an), 32'hf);
         endcase
         if (k >= 0) begin
            cnt[k]++;
            chk("digit_should_be_lit", 32'(lit[k]), 32'd1);
            chk("seg_code", 32'(seg), 32'(seg_ref[d[k]]));
            if (v >= 100 && prev >= 0 && k != prev) chk("scan_order", k, (prev + 1) % 3);
            prev = k;
         end
      end
      nlit = 0;
      for (int i = 0; i < 3; i++) begin
         chk("digit_dwell", cnt[i], lit[i] ? CLK_DIV : 0);
         nlit += lit[i] ? 1 : 0;
      end
      chk("blank_dwell", nblank, CLK_DIV * (3 - nlit));
   endtask

   task automatic convert_check(input int v, input logic [11:0] prev_bcd);
      value = 8'(v);
      cycles(9);
      chk("bcd_hold", 32'(bcd), 32'(prev_bcd));
      cycles(1);
      chk("bcd_result", 32'(bcd), 32'(to_bcd(v)));
      chk("bcd_valid_high", 32'(bcd_valid), 32'd1);
      cycles(1);
      scan_check(v);
   endtask

   initial begin
      int cur, v;
      tbl[0] = '{255, 12'h255};
      tbl[1] = '{7,   12'h007};
      tbl[2] = '{100, 12'h100};
      tbl[3] = '{0,   12'h000};
      rst = 1'b1;
      value = 8'd0;
      cycles(3);
      chk("rst_bcd", 32'(bcd), 32'h0);
      chk("rst_valid", 32'(bcd_valid), 32'd0);
      chk("rst_an", 32'(an), 32'hf);
      chk("rst_seg", 32'(seg), 32'h7f);
      chk("rst_dp", 32'(dp), 32'd1);
      rst = 1'b0;
      cycles(9);
      chk("forced_valid_early", 32'(bcd_valid), 32'd0);
      cycles(1);
      chk("forced_valid", 32'(bcd_valid), 32'd1);
      chk("forced_bcd", 32'(bcd), 32'h0);
      cycles(1);
      scan_check(0);
      cur = 0;
      for (int i = 0; i < 4; i++) begin
         value = 8'(tbl[i].v);
         cycles(9);
         chk("tbl_bcd_hold", 32'(bcd), 32'(to_bcd(cur)));
         cycles(1);
         chk("tbl_bcd", 32'(bcd), 32'(tbl[i].exp_bcd));
         cycles(1);
         scan_check(tbl[i].v);
         cur = tbl[i].v;
      end
      for (int i = 0; i < 10; i++) begin
         v = int'($urandom_range(13, 254));
         if (v == cur) v++;
         convert_check(v, to_bcd(cur));
         cur = v;
      end
      value = 8'd12;
      cycles(3);
      value = 8'd200;
      cycles(6);
      chk("mid_bcd_hold", 32'(bcd), 32'(to_bcd(cur)));
      cycles(1);
      chk("mid_bcd_first", 32'(bcd), 32'h012);
      cycles(9);
      chk("mid_bcd_still_first", 32'(bcd), 32'h012);
      cycles(2);
      chk("mid_bcd_second", 32'(bcd), 32'h200);
      cycles(1);
      scan_check(200);
      value = 8'd99;
      cycles(4);
      rst = 1'b1;
      cycles(1);
      chk("midrst_an", 32'(an), 32'hf);
      chk("midrst_seg", 32'(seg), 32'h7f);
      chk("midrst_valid", 32'(bcd_valid), 32'd0);
      chk("midrst_bcd", 32'(bcd), 32'h0);
      rst = 1'b0;
      cycles(9);
      chk("midrst_valid_early", 32'(bcd_valid), 32'd0);
      cycles(1);
      chk("midrst_valid_late", 32'(bcd_valid), 32'd1);
      chk("midrst_bcd_result", 32'(bcd), 32'h099);
      cycles(1);
      scan_check(99);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
